// File: rtl/serial_alu_pkg.sv
// Shared ALU opcode encoding and sequencer state type for the bit-serial ALU.
package serial_alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_NAND = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_bitslice.sv
// One-bit ALU slice: r1 = r2 op r3 with carry chain for ADD/SUB.
module bitSlice
  import serial_alu_pkg::*;
(
  input  logic       r2,
  input  logic       r3,
  input  logic [2:0] ALUop,
  input  logic       c_in,
  output logic       r1,
  output logic       c_out
);

  logic w_b;

  // SUB is a + ~b + 1; the +1 comes from the carry register preset at accept.
  assign w_b = (ALUop == ALU_SUB) ? ~r3 : r3;

  always_comb begin
    r1    = 1'b0;
    c_out = 1'b0;
    case (ALUop)
      ALU_AND:  r1 = r2 & r3;
      ALU_OR:   r1 = r2 | r3;
      ALU_XOR:  r1 = r2 ^ r3;
      ALU_ADD,
      ALU_SUB: begin
        r1    = r2 ^ w_b ^ c_in;
        c_out = (r2 & w_b) | (r2 & c_in) | (w_b & c_in);
      end
      ALU_NOR:  r1 = ~(r2 | r3);
      ALU_NAND: r1 = ~(r2 & r3);
      ALU_PASS: r1 = r2;
      default:  r1 = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU sequencer: shifts operands LSB-first through one bitSlice,
// assembling the result MSB-in over WIDTH cycles.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       ALUop,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic             r_carry;
  logic             w_accept, w_last, w_r1, w_cout;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  bitSlice u_slice (
    .r1    (w_r1),
    .r2    (r_a[0]),
    .r3    (r_b[0]),
    .ALUop (r_op),
    .c_in  (r_carry),
    .c_out (w_cout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= ALU_AND;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a     <= op_a;
      r_b     <= op_b;
      r_op    <= ALUop;
      r_cnt   <= '0;
      r_carry <= (ALUop == ALU_SUB);
    end else if (r_state == RUN) begin
      r_a      <= {1'b0, r_a[WIDTH-1:1]};
      r_b      <= {1'b0, r_b[WIDTH-1:1]};
      r_result <= {w_r1, r_result[WIDTH-1:1]};
      r_carry  <= w_cout;
      // Counter parks at WIDTH-1 on the last bit so it never wraps.
      if (!w_last) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ready  = (r_state == IDLE) || (r_state == DONE);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign c_out  = r_carry & is_arith(r_op);
  assign zero   = (r_result == '0);

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=8) against an arithmetic reference model.
module tb_serial_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [2:0]   ALUop = '0;
  logic         ready, done, c_out, zero;
  logic [W-1:0] result;

  int nvec = 0;
  int nerr = 0;

  serial_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .ALUop  (ALUop),
    .ready  (ready),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  // Reference model: {carry, result} from plain arithmetic on whole words.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] op);
    logic [W:0] s;
    case (op)
      3'd0: s = {1'b0, a & b};
      3'd1: s = {1'b0, a | b};
      3'd2: s = {1'b0, a ^ b};
      3'd3: s = {1'b0, a} + {1'b0, b};
      3'd4: s = {(a >= b), W'(a - b)};
      3'd5: s = {1'b0, ~(a | b)};
      3'd6: s = {1'b0, ~(a & b)};
      default: s = {1'b0, a};
    endcase
    return s;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    @(negedge clk);
    op_a = a; op_b = b; ALUop = op; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    #2;
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b want 1", ready); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done: got %b want 0", done); end
    nvec++; if (result !== '0) begin nerr++; $display("FAIL rst_result: got %h want 00", result); end
    nvec++; if (c_out !== 1'b0) begin nerr++; $display("FAIL rst_cout: got %b want 0", c_out); end
    nvec++; if (zero !== 1'b1) begin nerr++; $display("FAIL rst_zero: got %b want 1", zero); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [9] = '{8'hFF, 8'h05, 8'h07, 8'hF0, 8'hAA, 8'h81, 8'h0C, 8'h0F, 8'hFF};
    logic [W-1:0] tb [9] = '{8'h01, 8'h07, 8'h05, 8'h3C, 8'hFF, 8'h5A, 8'h30, 8'hF0, 8'hFF};
    logic [2:0]   to [9] = '{3'd3, 3'd4, 3'd4, 3'd0, 3'd2, 3'd7, 3'd1, 3'd5, 3'd6};
    logic [W-1:0] er [9] = '{8'h00, 8'hFE, 8'h02, 8'h30, 8'h55, 8'h81, 8'h3C, 8'h00, 8'h00};
    logic         ec [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 9; i++) begin
      issue(ta[i], tb[i], to[i]);
      wait_done(lat);
      nvec++; if (lat != W) begin nerr++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, W); end
      nvec++; if (result !== er[i]) begin nerr++; $display("FAIL dir%0d_result: got %h want %h", i, result, er[i]); end
      nvec++; if (c_out !== ec[i]) begin nerr++; $display("FAIL dir%0d_cout: got %b want %b", i, c_out, ec[i]); end
      nvec++; if (zero !== (er[i] == 0)) begin nerr++; $display("FAIL dir%0d_zero: got %b want %b", i, zero, er[i] == 0); end
      @(posedge clk); #1;
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL dir%0d_pulse: got %b want 0", i, done); end
      nvec++; if (result !== er[i]) begin nerr++; $display("FAIL dir%0d_hold: got %h want %h", i, result, er[i]); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic [W:0]   m;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 7));
      m = model(a, b, op);
      issue(a, b, op);
      wait_done(lat);
      nvec++; if (lat != W) begin nerr++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, W); end
      nvec++; if (result !== m[W-1:0]) begin nerr++; $display("FAIL rnd%0d_result op%0d %h,%h: got %h want %h", i, op, a, b, result, m[W-1:0]); end
      nvec++; if (c_out !== m[W]) begin nerr++; $display("FAIL rnd%0d_cout: got %b want %b", i, c_out, m[W]); end
      nvec++; if (zero !== (m[W-1:0] == 0)) begin nerr++; $display("FAIL rnd%0d_zero: got %b want %b", i, zero, m[W-1:0] == 0); end
    end
  endtask

  task automatic test_start_mid_run();
    logic [W-1:0] a, b;
    logic [W:0]   m;
    int lat, pulses;
    a = 8'h3A; b = 8'h59;
    m = model(a, b, 3'd3);
    issue(a, b, 3'd3);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
      if (n == 3) begin op_a = 8'hC3; op_b = 8'h11; ALUop = 3'd4; start = 1'b1; end
      else if (n == 4) start = 1'b0;
    end
    nvec++; if (lat != W) begin nerr++; $display("FAIL mid_latency: got %0d want %0d", lat, W); end
    nvec++; if (result !== m[W-1:0]) begin nerr++; $display("FAIL mid_result: got %h want %h", result, m[W-1:0]); end
    nvec++; if (c_out !== m[W]) begin nerr++; $display("FAIL mid_cout: got %b want %b", c_out, m[W]); end
    pulses = 0;
    for (int n = 0; n < 20; n++) begin @(posedge clk); #1; if (done) pulses++; end
    nvec++; if (pulses != 0) begin nerr++; $display("FAIL mid_extra_done: got %0d want 0", pulses); end
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL mid_ready: got %b want 1", ready); end
  endtask

  task automatic test_reset_mid_run();
    int lat, pulses;
    issue(8'h3C, 8'h0F, 3'd3);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL rmid_ready: got %b want 1", ready); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rmid_done: got %b want 0", done); end
    nvec++; if (result !== '0) begin nerr++; $display("FAIL rmid_result: got %h want 00", result); end
    nvec++; if (c_out !== 1'b0) begin nerr++; $display("FAIL rmid_cout: got %b want 0", c_out); end
    nvec++; if (zero !== 1'b1) begin nerr++; $display("FAIL rmid_zero: got %b want 1", zero); end
    @(posedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin @(posedge clk); #1; if (done) pulses++; end
    nvec++; if (pulses != 0) begin nerr++; $display("FAIL rmid_no_done: got %0d want 0", pulses); end
    issue(8'h10, 8'h20, 3'd3);
    wait_done(lat);
    nvec++; if (lat != W) begin nerr++; $display("FAIL rmid_new_latency: got %0d want %0d", lat, W); end
    nvec++; if (result !== 8'h30) begin nerr++; $display("FAIL rmid_new_result: got %h want 30", result); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    logic [2:0]   o1, o2;
    logic [W:0]   m1, m2;
    int lat1, lat2;
    for (int i = 0; i < 3; i++) begin
      a1 = W'($urandom); b1 = W'($urandom); o1 = 3'($urandom_range(0, 7));
      a2 = W'($urandom); b2 = W'($urandom); o2 = 3'($urandom_range(3, 4));
      m1 = model(a1, b1, o1);
      m2 = model(a2, b2, o2);
      @(negedge clk);
      op_a = a1; op_b = b1; ALUop = o1; start = 1'b1;
      @(posedge clk);
      #1 op_a = a2; op_b = b2; ALUop = o2;
      wait_done(lat1);
      nvec++; if (lat1 != W) begin nerr++; $display("FAIL b2b%0d_lat1: got %0d want %0d", i, lat1, W); end
      nvec++; if (result !== m1[W-1:0]) begin nerr++; $display("FAIL b2b%0d_res1: got %h want %h", i, result, m1[W-1:0]); end
      nvec++; if (c_out !== m1[W]) begin nerr++; $display("FAIL b2b%0d_cout1: got %b want %b", i, c_out, m1[W]); end
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat2);
      nvec++; if (lat2 + 1 != W + 1) begin nerr++; $display("FAIL b2b%0d_gap: got %0d want %0d", i, lat2 + 1, W + 1); end
      nvec++; if (result !== m2[W-1:0]) begin nerr++; $display("FAIL b2b%0d_res2: got %h want %h", i, result, m2[W-1:0]); end
      nvec++; if (c_out !== m2[W]) begin nerr++; $display("FAIL b2b%0d_cout2: got %b want %b", i, c_out, m2[W]); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_mid_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
